// File: rtl/cpu_ctrl_pkg.sv
// Shared state encodings and opcode constants
// for the instruction-sequencing control unit.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BRZ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/cpu_pc_unit.sv
// Program counter register: load has priority
// over increment; increment wraps naturally.
module cpu_pc_unit #(
    parameter int PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_value,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_VECTOR;
        else if (load)
            pc <= load_value;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute sequencer with ROM wait handshake and HALT.
// Optional ROM timeout enabled by CPU_CTRL_MEM_TIMEOUT_EN.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rom_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero_flag,
    input  logic [PC_WIDTH-1:0]     branch_target,
    input  logic                    resume,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [PC_WIDTH-1:0]     rom_addr,
    output logic                    rom_read_enable,
    output logic                    ir_load,
    output logic                    exec_enable,
    output logic                    halted,
    output logic [2:0]              state,
    output logic                    mem_fault
);

    localparam logic [OPCODE_WIDTH-1:0] OPC_JMP  = OPCODE_WIDTH'(OP_JMP);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRZ  = OPCODE_WIDTH'(OP_BRZ);
    localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = OPCODE_WIDTH'(OP_HALT);

    state_t state_q;
    state_t state_d;
    logic   timeout;
    logic   fault_q;
    logic   take;
    logic   pc_inc;
    logic   pc_load;

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Fires on the last allowed WAIT_MEM cycle that still sees no data.
    assign timeout = (state_q == ST_WAIT_MEM) && !rom_ready &&
                     (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state_q == ST_FETCH)
                wait_cnt <= '0;
            else if (state_q == ST_WAIT_MEM)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                fault_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign fault_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:
                state_d = rom_ready ? ST_DECODE : ST_WAIT_MEM;
            ST_WAIT_MEM:
                if (rom_ready)
                    state_d = ST_DECODE;
                else if (timeout)
                    state_d = ST_HALT;
            ST_DECODE:
                state_d = ST_EXECUTE;
            ST_EXECUTE:
                state_d = (opcode == OPC_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:
                if (resume && !fault_q)
                    state_d = ST_FETCH;
            default:
                state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        rom_read_enable = 1'b0;
        exec_enable     = 1'b0;
        halted          = 1'b0;
        case (state_q)
            ST_FETCH,
            ST_WAIT_MEM: rom_read_enable = !reset;
            ST_EXECUTE:  exec_enable = 1'b1;
            ST_HALT:     halted = 1'b1;
            default:     ;
        endcase
        ir_load = rom_read_enable & rom_ready;
        take    = (opcode == OPC_JMP) ||
                  ((opcode == OPC_BRZ) && zero_flag);
        pc_load = exec_enable & take;
        pc_inc  = exec_enable & !take;
    end

    cpu_pc_unit #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (branch_target),
        .pc         (pc)
    );

    assign rom_addr  = pc;
    assign state     = state_q;
    assign mem_fault = fault_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with an instruction-level
// reference model checked every cycle plus literal spot checks.
module tb_cpu_ctrl_fsm;

    localparam int PW  = 8;
    localparam int OW  = 4;
    localparam int TMO = 15;
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          rom_ready;
    logic [OW-1:0] opcode;
    logic          zero_flag;
    logic [PW-1:0] branch_target;
    logic          resume;
    logic [PW-1:0] pc;
    logic [PW-1:0] rom_addr;
    logic          rom_read_enable;
    logic          ir_load;
    logic          exec_enable;
    logic          halted;
    logic [2:0]    state;
    logic          mem_fault;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    int m_st;
    int m_pc;
    int m_waits;
    bit m_fault;

    cpu_ctrl_fsm #(
        .PC_WIDTH     (PW),
        .OPCODE_WIDTH (OW),
        .RESET_VECTOR (8'h00),
        .MEM_TIMEOUT  (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rom_ready       (rom_ready),
        .opcode          (opcode),
        .zero_flag       (zero_flag),
        .branch_target   (branch_target),
        .resume          (resume),
        .pc              (pc),
        .rom_addr        (rom_addr),
        .rom_read_enable (rom_read_enable),
        .ir_load         (ir_load),
        .exec_enable     (exec_enable),
        .halted          (halted),
        .state           (state),
        .mem_fault       (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Reference: 0 fetch, 1 wait, 2 decode, 3 execute, 4 halt.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st    <= 0;
            m_pc    <= 0;
            m_waits <= 0;
            m_fault <= 1'b0;
        end else begin
            case (m_st)
                0: begin
                    m_waits <= 0;
                    m_st    <= rom_ready ? 2 : 1;
                end
                1: begin
                    if (rom_ready) begin
                        m_st <= 2;
                    end else begin
                        m_waits <= m_waits + 1;
                        if (TMO_EN && m_waits + 1 >= TMO) begin
                            m_st    <= 4;
                            m_fault <= 1'b1;
                        end
                    end
                end
                2: m_st <= 3;
                3: begin
                    if (opcode == 4'hC || (opcode == 4'hD && zero_flag))
                        m_pc <= int'(branch_target);
                    else
                        m_pc <= (m_pc + 1) % (1 << PW);
                    m_st <= (opcode == 4'hF) ? 4 : 0;
                end
                default: if (resume && !m_fault) m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            automatic bit rre = !reset && (m_st == 0 || m_st == 1);
            chk("state", int'(state), m_st);
            chk("pc", int'(pc), m_pc);
            chk("rom_addr", int'(rom_addr), m_pc);
            chk("rom_read_enable", int'(rom_read_enable), int'(rre));
            chk("ir_load", int'(ir_load), int'(rre && rom_ready));
            chk("exec_enable", int'(exec_enable), int'(m_st == 3));
            chk("halted", int'(halted), int'(m_st == 4));
            chk("mem_fault", int'(mem_fault), int'(m_fault));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic z,
                         input logic [7:0] tgt);
        opcode        = op;
        zero_flag     = z;
        branch_target = tgt;
        step(3);
    endtask

    initial begin
        reset         = 1'b1;
        rom_ready     = 1'b1;
        opcode        = '0;
        zero_flag     = 1'b0;
        branch_target = '0;
        resume        = 1'b0;
        step(1);
        chk_on = 1'b1;
        step(1);
        chk("rst_state", int'(state), 0);
        chk("rst_rre", int'(rom_read_enable), 0);
        reset = 1'b0;

        instr(4'h0, 1'b0, 8'h00);
        chk("seq_pc1", int'(pc), 1);
        instr(4'h0, 1'b0, 8'h00);
        instr(4'h0, 1'b0, 8'h00);
        chk("seq_pc3", int'(pc), 3);

        rom_ready = 1'b0;
        step(1);
        chk("wait_state", int'(state), 1);
        step(3);
        chk("wait_addr", int'(rom_addr), 3);
        chk("wait_irl", int'(ir_load), 0);
        rom_ready = 1'b1;
        #1;
        chk("ready_irl", int'(ir_load), 1);
        step(3);
        chk("wait_done_pc", int'(pc), 4);

        instr(4'hC, 1'b0, 8'h40);
        chk("jmp_pc", int'(pc), 8'h40);
        instr(4'hD, 1'b0, 8'h10);
        chk("brz_nt_pc", int'(pc), 8'h41);
        instr(4'hD, 1'b1, 8'h10);
        chk("brz_t_pc", int'(pc), 8'h10);
        instr(4'hC, 1'b0, 8'hFF);
        instr(4'h0, 1'b0, 8'h00);
        chk("wrap_pc", int'(pc), 8'h00);

        instr(4'hC, 1'b0, 8'h05);
        instr(4'hF, 1'b0, 8'h00);
        chk("halt_state", int'(state), 4);
        chk("halt_pc", int'(pc), 6);
        opcode = 4'h0;
        step(10);
        chk("halt_hold", int'(halted), 1);
        resume = 1'b1;
        step(1);
        resume = 1'b0;
        chk("resume_state", int'(state), 0);
        chk("resume_addr", int'(rom_addr), 6);
        resume = 1'b1;
        instr(4'h0, 1'b0, 8'h00);
        resume = 1'b0;
        chk("resume_ign_pc", int'(pc), 7);

        rom_ready = 1'b0;
        step(2);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_pc", int'(pc), 0);
        chk("midrst_rre", int'(rom_read_enable), 0);
        step(1);
        reset = 1'b0;

        if (TMO_EN) begin
            step(1 + TMO - 1);
            chk("tmo_last_wait", int'(state), 1);
            step(1);
            chk("tmo_state", int'(state), 4);
            chk("tmo_fault", int'(mem_fault), 1);
            chk("tmo_pc", int'(pc), 0);
            resume = 1'b1;
            step(5);
            chk("tmo_resume_ign", int'(state), 4);
            resume = 1'b0;
        end else begin
            step(21);
            chk("nofault_wait", int'(state), 1);
            chk("nofault_flag", int'(mem_fault), 0);
            resume = 1'b1;
            step(2);
            resume = 1'b0;
            chk("wait_resume_ign", int'(state), 1);
            rom_ready = 1'b1;
            step(3);
            chk("late_ready_pc", int'(pc), 1);
        end

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Parametrised instruction-sequencing control unit; successor to the fixed 8-bit fetch/decode/execute sequencer.
- Drives the instruction ROM through a ready/valid wait handshake and pulses the IR load.
- Issues a one-cycle execute strobe to the datapath.
- Updates the PC by increment, jump or conditional branch, and supports a HALT state with external resume.

Parameters:
- PC_WIDTH, 8: width of pc, rom_addr and branch_target.
- OPCODE_WIDTH, 4: width of the opcode input from the IR.
- RESET_VECTOR, 0: pc value loaded on reset; must fit in PC_WIDTH.
- MEM_TIMEOUT, 15: maximum wait cycles for rom_ready. Used only with CPU_CTRL_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_ready  in  1  ROM data valid for rom_addr this cycle.
- opcode  in  OPCODE_WIDTH  opcode field of the IR; valid from DECODE onward.
- zero_flag  in  1  ALU zero flag; sampled in EXECUTE.
- branch_target  in  PC_WIDTH  jump/branch destination from the IR operand.
- resume  in  1  leave HALT; level-sampled.
- pc  out  PC_WIDTH  program counter.
- rom_addr  out  PC_WIDTH  equals pc.
- rom_read_enable  out  1  ROM read request.
- ir_load  out  1  IR capture strobe.
- exec_enable  out  1  one-cycle datapath execute strobe.
- halted  out  1  high while in HALT.
- state  out  3  current state encoding, for debug.
- mem_fault  out  1  sticky ROM timeout flag.

Behaviour:
- Reset (asynchronous, takes effect immediately in any state, including mid-wait):
  - pc = RESET_VECTOR, state = FETCH, mem_fault = 0, wait counter = 0.
  - exec_enable = 0, halted = 0.
  - While reset is held, rom_read_enable and ir_load are 0.
- States: FETCH=0, WAIT_MEM=1, DECODE=2, EXECUTE=3, HALT=4. Encodings 5-7 go to FETCH on the next edge; pc is unchanged.
- Output decoding:
  - rom_read_enable = 1 in FETCH and WAIT_MEM. Moore output, decoded from the state register.
  - ir_load = rom_read_enable & rom_ready. Mealy output; the IR captures on that edge.
  - exec_enable = 1 only in EXECUTE. halted = 1 only in HALT.
- FETCH: rom_ready=1 -> DECODE; otherwise -> WAIT_MEM.
- WAIT_MEM: stay until rom_ready=1, then -> DECODE. rom_addr is held stable for the whole wait.
- DECODE: always -> EXECUTE. No outputs beyond the state encoding.
- EXECUTE: pc update depends on opcode; next state is FETCH unless stated.
  - OP_JMP: pc <= branch_target.
  - OP_BRZ with zero_flag=1: pc <= branch_target.
  - OP_BRZ with zero_flag=0: pc <= pc+1.
  - OP_HALT: pc <= pc+1, next state HALT.
  - Any other opcode: pc <= pc+1.
- PC arithmetic: pc+1 wraps modulo 2^PC_WIDTH (all-ones -> 0). A branch to the current pc is legal (self-loop).
- HALT: stay while resume=0; resume=1 -> FETCH at the already-incremented pc. resume is ignored in every other state.
- Latency per instruction: 3 cycles with zero ROM wait; 3+N cycles with N wait cycles.
- Simultaneous events: reset dominates resume and rom_ready. Opcode and flag are sampled only in EXECUTE.

Optional Feature:
- Macro: CPU_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH and increments each WAIT_MEM cycle.
  - If MEM_TIMEOUT WAIT_MEM cycles pass without rom_ready, the next edge goes to HALT with mem_fault <= 1 and pc unchanged.
  - mem_fault stays set until reset; resume is ignored while mem_fault=1.
- Undefined: no counter; WAIT_MEM waits indefinitely; mem_fault is tied to 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - State encodings ST_FETCH..ST_HALT (3 bits).
  - Opcode constants OP_JMP=4'hC, OP_BRZ=4'hD, OP_HALT=4'hF, sized by OPCODE_WIDTH.
- Sub-module cpu_pc_unit: PC register with async reset to RESET_VECTOR and inputs inc, load and load_value. The FSM drives inc/load in EXECUTE.

Test Plan:
- Reset, rom_ready tied 1, opcode 4'h0 -> pc 0,1,2 on cycles 3,6,9; ir_load high every FETCH cycle; exec_enable high 1 cycle in 3.
- rom_ready low 4 cycles after FETCH -> state 1 for 4 cycles, rom_read_enable held, rom_addr stable, ir_load only on the ready cycle; total 7 cycles for the instruction.
- Branch cases:
  - OP_JMP with target 8'h40 -> pc=8'h40.
  - OP_BRZ with zero_flag=0 at pc 8'h40 -> 8'h41.
  - OP_BRZ with zero_flag=1, target 8'h10 -> 8'h10.
- pc=8'hFF, opcode 4'h0 -> pc wraps to 8'h00.
- OP_HALT at pc 5 -> halted=1, pc=6, no ROM reads for 10 cycles; resume pulse -> FETCH with rom_addr=6.
- Reset asserted mid-WAIT_MEM -> state=0 and pc=RESET_VECTOR immediately. With CPU_CTRL_MEM_TIMEOUT_EN and rom_ready held 0 -> HALT plus mem_fault=1 after 15 wait cycles; resume ignored.
